// File: rtl/i2cmb_txn_sequencer.sv
// Wishbone-master sequencer: arbitrates byte-transaction requesters and drives the
// iicmb_m_wb register sequence (set bus, start, address, data, stop) for each grant.
module i2cmb_txn_sequencer #(
  parameter int         NUM_REQ        = 2,
  parameter logic [7:0] I2C_BUS_ID     = 8'h00,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         WB_ADDR_WIDTH  = 2,
  parameter int         WB_DATA_WIDTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         rw_i,
  input  logic [7*NUM_REQ-1:0]       addr_i,
  input  logic [8*NUM_REQ-1:0]       wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       done_o,
  output logic [7:0]                 rdata_o,
  output logic [1:0]                 status_o,
  output logic                       cyc_o,
  output logic                       stb_o,
  output logic                       we_o,
  output logic [WB_ADDR_WIDTH-1:0]   adr_o,
  output logic [WB_DATA_WIDTH-1:0]   dat_o,
  input  logic [WB_DATA_WIDTH-1:0]   dat_i,
  input  logic                       ack_i,
  input  logic                       irq_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(2'd0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(2'd1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2'd2);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_PHASE, ST_CMD, ST_ACC, ST_WAIT,
    ST_DECODE, ST_RDPR, ST_RECOV, ST_RESP, ST_DROP
  } state_t;

  typedef enum logic [2:0] {PH_BUS, PH_START, PH_ADDR, PH_DATA, PH_STOP} phase_t;

  state_t           state_r;
  state_t           nxt_r;
  phase_t           phase_r;
  logic [IDX_W-1:0] ptr_r;
  logic             rw_r;
  logic [6:0]       addr_r;
  logic [7:0]       wdata_r;
  logic [3:0]       flags_r;
  logic [7:0]       rdhold_r;
  logic [1:0]       status_r;
  logic [TMO_W-1:0] tmo_r;
  logic [IDX_W-1:0] pick_s;
  logic             found_s;
  int               j_s;

  function automatic logic [7:0] cmd_code(input phase_t ph, input logic rd);
    case (ph)
      PH_BUS:   cmd_code = 8'h06;
      PH_START: cmd_code = 8'h04;
      PH_ADDR:  cmd_code = 8'h01;
      PH_DATA:  cmd_code = rd ? 8'h03 : 8'h01;
      default:  cmd_code = 8'h05;
    endcase
  endfunction

  // Round-robin pick: first asserting requester at or after the pointer.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    j_s     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j_s = (int'(ptr_r) + i) % NUM_REQ;
      if (!found_s && req_i[j_s]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(j_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Main sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r  <= ST_INIT;
      nxt_r    <= ST_IDLE;
      phase_r  <= PH_BUS;
      ptr_r    <= '0;
      rw_r     <= 1'b0;
      addr_r   <= 7'h00;
      wdata_r  <= 8'h00;
      flags_r  <= 4'h0;
      rdhold_r <= 8'h00;
      status_r <= 2'd0;
      tmo_r    <= '0;
      gnt_o    <= '0;
      done_o   <= 1'b0;
      rdata_o  <= 8'h00;
      status_o <= 2'd0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= ADR_CSR;
      dat_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_INIT, ST_RECOV: begin
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          we_o    <= 1'b1;
          adr_o   <= ADR_CSR;
          dat_o   <= WB_DATA_WIDTH'(8'hC0);
          nxt_r   <= (state_r == ST_INIT) ? ST_IDLE : ST_RESP;
          state_r <= ST_ACC;
        end
        ST_IDLE: begin
          if (found_s) begin
            gnt_o    <= NUM_REQ'(1'b1) << pick_s;
            ptr_r    <= IDX_W'((int'(pick_s) + 1) % NUM_REQ);
            rw_r     <= rw_i[pick_s];
            addr_r   <= addr_i[7*int'(pick_s) +: 7];
            wdata_r  <= wdata_i[8*int'(pick_s) +: 8];
            phase_r  <= PH_BUS;
            status_r <= 2'd0;
            rdhold_r <= 8'h00;
            state_r  <= ST_PHASE;
          end
        end
        ST_PHASE: begin
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          we_o    <= 1'b1;
          state_r <= ST_ACC;
          if (phase_r == PH_BUS || phase_r == PH_ADDR || (phase_r == PH_DATA && !rw_r)) begin
            adr_o <= ADR_DPR;
            dat_o <= (phase_r == PH_BUS)  ? WB_DATA_WIDTH'(I2C_BUS_ID) :
                     (phase_r == PH_ADDR) ? WB_DATA_WIDTH'({addr_r, rw_r}) :
                                            WB_DATA_WIDTH'(wdata_r);
            nxt_r <= ST_CMD;
          end else begin
            adr_o <= ADR_CMDR;
            dat_o <= WB_DATA_WIDTH'(cmd_code(phase_r, rw_r));
            nxt_r <= ST_WAIT;
          end
        end
        ST_CMD: begin
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          we_o    <= 1'b1;
          adr_o   <= ADR_CMDR;
          dat_o   <= WB_DATA_WIDTH'(cmd_code(phase_r, rw_r));
          nxt_r   <= ST_WAIT;
          state_r <= ST_ACC;
        end
        ST_ACC: begin
          if (ack_i) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= ADR_CSR;
            dat_o   <= '0;
            tmo_r   <= '0;
            state_r <= nxt_r;
            if (!we_o) begin
              flags_r <= dat_i[7:4];
            end
            if (!we_o && adr_o == ADR_DPR) begin
              rdhold_r <= dat_i[7:0];
            end
          end
        end
        ST_WAIT: begin
          if (irq_i) begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            we_o    <= 1'b0;
            adr_o   <= ADR_CMDR;
            dat_o   <= '0;
            nxt_r   <= ST_DECODE;
            state_r <= ST_ACC;
          end else if (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Controller unresponsive: pulse the core enable off and back on.
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            we_o     <= 1'b1;
            adr_o    <= ADR_CSR;
            dat_o    <= WB_DATA_WIDTH'(8'h00);
            status_r <= 2'd3;
            nxt_r    <= ST_RECOV;
            state_r  <= ST_ACC;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_DECODE: begin
          // flags_r = {DON, NAK, AL, ERR}
          if (flags_r[1] || flags_r[0]) begin
            status_r <= 2'd2;
            state_r  <= ST_RESP;
          end else if (flags_r[2] && (phase_r == PH_ADDR || phase_r == PH_DATA)) begin
            status_r <= 2'd1;
            phase_r  <= PH_STOP;
            state_r  <= ST_PHASE;
          end else if (!flags_r[3]) begin
            status_r <= 2'd2;
            state_r  <= ST_RESP;
          end else begin
            case (phase_r)
              PH_BUS:   begin phase_r <= PH_START; state_r <= ST_PHASE; end
              PH_START: begin phase_r <= PH_ADDR;  state_r <= ST_PHASE; end
              PH_ADDR:  begin phase_r <= PH_DATA;  state_r <= ST_PHASE; end
              PH_DATA:  begin phase_r <= PH_STOP;  state_r <= rw_r ? ST_RDPR : ST_PHASE; end
              default:  state_r <= ST_RESP;
            endcase
          end
        end
        ST_RDPR: begin
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          we_o    <= 1'b0;
          adr_o   <= ADR_DPR;
          dat_o   <= '0;
          nxt_r   <= ST_PHASE;
          state_r <= ST_ACC;
        end
        ST_RESP: begin
          done_o   <= 1'b1;
          status_o <= status_r;
          rdata_o  <= (status_r == 2'd0 && rw_r) ? rdhold_r : 8'h00;
          state_r  <= ST_DROP;
        end
        ST_DROP: begin
          gnt_o   <= '0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_txn_sequencer.sv
// Randomized bench for i2cmb_txn_sequencer with a register-level controller/slave
// model and a transaction-level reference for Wishbone write order, status and data.
module tb_i2cmb_txn_sequencer;
  localparam int NR  = 3;
  localparam int TMO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NR-1:0] req, rw, gnt;
  logic [7*NR-1:0] addr;
  logic [8*NR-1:0] wdata;
  logic          done, cyc, stb, we, ack, irq;
  logic [7:0]    rdata, dat_o, dat_i;
  logic [1:0]    status, adr;

  i2cmb_txn_sequencer #(.NUM_REQ(NR), .I2C_BUS_ID(8'h00), .TIMEOUT_CYCLES(TMO),
                        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .status_o(status),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i),
    .ack_i(ack), .irq_i(irq));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Controller/slave model state
  bit         present [128];
  logic [7:0] rd_val  [128];
  bit         al_mode, hang_mode;
  logic [7:0] cmdr_res, dpr_w, dpr_rd;
  logic [6:0] cur_slave;
  bit         expect_addr;
  int         irq_cnt;
  logic [9:0] wlog [$];
  logic [9:0] exp_q [$];
  int         cyc_n = 0, t_start = 0, t_done = 0, done_cnt = 0;
  logic [NR-1:0] done_gnt;
  logic [1:0] done_status;
  logic [7:0] done_rdata;
  bit         idle_chk;

  assign dat_i = (adr == 2'd2) ? cmdr_res : (adr == 2'd1) ? dpr_rd : 8'h00;

  // iicmb_m_wb register behaviour plus a bus monitor
  always @(posedge clk) begin : model
    logic [7:0] r;
    bit         hang;
    cyc_n++;
    if (done) begin
      done_cnt++;
      done_gnt    = gnt;
      done_status = status;
      done_rdata  = rdata;
      t_done      = cyc_n;
    end
    idle_chk <= cyc && stb && ack;
    if (!rst_n) begin
      ack <= 1'b0; irq <= 1'b0; irq_cnt <= 0; expect_addr <= 1'b0;
    end else begin
      ack <= cyc && stb && !ack;
      if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1'b1;
      end
      if (cyc && stb && ack) begin
        if (we) wlog.push_back({adr, dat_o});
        if (we && adr == 2'd1) dpr_w <= dat_o;
        if (we && adr == 2'd2) begin
          r = 8'h80;
          hang = 1'b0;
          case (dat_o)
            8'h04: begin
              r = al_mode ? 8'h20 : 8'h80;
              hang = hang_mode;
              expect_addr <= 1'b1;
              t_start = cyc_n;
            end
            8'h01: begin
              if (expect_addr) begin
                expect_addr <= 1'b0;
                cur_slave <= dpr_w[7:1];
                r = present[dpr_w[7:1]] ? 8'h80 : 8'h40;
              end else begin
                r = present[cur_slave] ? 8'h80 : 8'h40;
              end
            end
            8'h03: dpr_rd <= rd_val[cur_slave];
            default: r = 8'h80;
          endcase
          cmdr_res <= r;
          if (!hang) irq_cnt <= $urandom_range(1, 6);
        end
        if (!we && adr == 2'd2) irq <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (idle_chk) chk("wb_idle", {30'd0, cyc, stb}, 32'd0);

  // Expected write sequence and result straight from the transaction rules
  logic [1:0] exp_status;
  logic [7:0] exp_rdata;
  task automatic build_exp(input bit r_w, input logic [6:0] a, input logic [7:0] wd,
                           input bit al, input bit hang);
    exp_q.delete();
    exp_rdata = 8'h00;
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h06});
    exp_q.push_back({2'd2, 8'h04});
    if (al) begin
      exp_status = 2'd2;
    end else if (hang) begin
      exp_q.push_back({2'd0, 8'h00});
      exp_q.push_back({2'd0, 8'hC0});
      exp_status = 2'd3;
    end else begin
      exp_q.push_back({2'd1, a, r_w});
      exp_q.push_back({2'd2, 8'h01});
      if (!present[a]) begin
        exp_status = 2'd1;
      end else if (r_w) begin
        exp_q.push_back({2'd2, 8'h03});
        exp_status = 2'd0;
        exp_rdata = rd_val[a];
      end else begin
        exp_q.push_back({2'd1, wd});
        exp_q.push_back({2'd2, 8'h01});
        exp_status = 2'd0;
      end
      exp_q.push_back({2'd2, 8'h05});
    end
  endtask

  task automatic wait_done();
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done_cnt != d0}, 32'd1);
  endtask

  task automatic reset_dut(input bit check_vals);
    bit early = 1'b0;
    int n = 0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (check_vals) begin
      chk("rst_wb", {26'd0, cyc, stb, we, adr, 1'b0}, 32'd0);
      chk("rst_dat", {24'd0, dat_o}, 32'd0);
      chk("rst_gnt", {29'd0, gnt}, 32'd0);
      chk("rst_done", {21'd0, done, status, rdata}, 32'd0);
    end
    wlog.delete();
    rst_n = 1'b1;
    while (wlog.size() == 0 && n < 50) begin
      @(negedge clk);
      if (gnt != '0) early = 1'b1;
      n++;
    end
    chk("init_gnt", {31'd0, early}, 32'd0);
    chk("init_csr", (wlog.size() > 0) ? {22'd0, wlog[0]} : 32'hFFFF, {22'd0, 2'd0, 8'hC0});
  endtask

  task automatic run_txn(input int r, input bit r_w, input logic [6:0] a, input logic [7:0] wd,
                         input bit al, input bit hang, input string tag);
    al_mode = al;
    hang_mode = hang;
    build_exp(r_w, a, wd, al, hang);
    @(negedge clk);
    wlog.delete();
    rw[r] = r_w;
    addr[7*r +: 7] = a;
    wdata[8*r +: 8] = wd;
    req[r] = 1'b1;
    wait_done();
    req[r] = 1'b0;
    chk({tag, "_gnt"}, {29'd0, done_gnt}, 32'd1 << r);
    chk({tag, "_status"}, {30'd0, done_status}, {30'd0, exp_status});
    chk({tag, "_rdata"}, {24'd0, done_rdata}, {24'd0, exp_rdata});
    chk({tag, "_nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, {22'd0, wlog[i]}, {22'd0, exp_q[i]});
  endtask

  initial begin
    int p, g, lat, d0, n;
    rst_n = 1'b1; req = '0; rw = '0; addr = '0; wdata = '0;
    al_mode = 1'b0; hang_mode = 1'b0;
    cmdr_res = 8'h00; dpr_w = 8'h00; dpr_rd = 8'h00; cur_slave = 7'h00;
    for (int i = 0; i < 128; i++) begin
      present[i] = ($urandom_range(0, 1) == 1);
      rd_val[i]  = 8'($urandom);
    end
    present[7'h22] = 1'b1;
    present[7'h10] = 1'b0;
    rd_val[7'h22]  = 8'hA7;

    reset_dut(1'b1);
    run_txn(0, 1'b0, 7'h22, 8'h5A, 1'b0, 1'b0, "write");
    run_txn(1, 1'b1, 7'h22, 8'h00, 1'b0, 1'b0, "read");
    run_txn(0, 1'b0, 7'h10, 8'h33, 1'b0, 1'b0, "nak");
    run_txn(2, 1'b1, 7'h22, 8'h00, 1'b1, 1'b0, "al");
    run_txn(1, 1'b0, 7'h22, 8'h11, 1'b0, 1'b1, "tmo");
    lat = t_done - t_start;
    chk("tmo_lat_lo", {31'd0, lat >= TMO}, 32'd1);
    chk("tmo_lat_hi", {31'd0, lat <= TMO + 20}, 32'd1);

    // Arbitration: every requester asserting from reset, served in rotation
    al_mode = 1'b0; hang_mode = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rw[i] = 1'b0; addr[7*i +: 7] = 7'h22; wdata[8*i +: 8] = 8'(i);
    end
    req = '1;
    reset_dut(1'b0);
    p = 0;
    for (int k = 0; k < 4; k++) begin
      g = p;
      wait_done();
      chk("arb_gnt", {29'd0, done_gnt}, 32'd1 << g);
      p = (g + 1) % NR;
    end
    req = '0;
    repeat (100) @(negedge clk);

    // Reset pulse while a Wishbone access is in flight
    rw[0] = 1'b0; addr[6:0] = 7'h22; wdata[7:0] = 8'h77;
    wlog.delete();
    req[0] = 1'b1;
    n = 0;
    while (!(wlog.size() >= 2 && stb) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_stb", {31'd0, stb}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_wb", {30'd0, cyc, stb}, 32'd0);
    chk("mid_rst_gnt", {29'd0, gnt}, 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    wlog.delete();
    d0 = done_cnt;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_no_done", done_cnt, d0);
    chk("mid_first_csr", (wlog.size() > 0) ? {22'd0, wlog[0]} : 32'hFFFF, {22'd0, 2'd0, 8'hC0});

    for (int k = 0; k < 40; k++) begin
      int r;
      bit r_w, al, hang;
      logic [6:0] a;
      r    = $urandom_range(0, NR - 1);
      r_w  = ($urandom_range(0, 1) == 1);
      a    = ($urandom_range(0, 1) == 1) ? 7'h22 : 7'($urandom);
      al   = ($urandom_range(0, 9) == 0);
      hang = !al && ($urandom_range(0, 19) == 0);
      run_txn(r, r_w, a, 8'($urandom), al, hang, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2cmb_txn_sequencer.md
# i2cmb_txn_sequencer

Wishbone-master sequencer that sits between up to NUM_REQ byte-transaction requesters and the iicmb_m_wb I2C multi-bus controller. It arbitrates requesters round-robin and issues the CSR/DPR/CMDR register-access sequence for one complete single-byte I2C transaction: set bus, start, address, data, stop. It waits on the controller's irq for each command and returns read data plus a completion status to the granted requester.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- I2C_BUS_ID, 0, 8-bit bus index written before every Set Bus command
- TIMEOUT_CYCLES, 65535, max clk_i cycles spent waiting for irq_i per command
- WB_ADDR_WIDTH, 2, Wishbone address width
- WB_DATA_WIDTH, 8, Wishbone data width

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- rst_n_i  in  1  reset, synchronous, active-low
- req_i  in  NUM_REQ  per-requester transaction request, held until done_o
- rw_i  in  NUM_REQ  per-requester: 1 = read, 0 = write
- addr_i  in  7*NUM_REQ  packed 7-bit I2C slave addresses
- wdata_i  in  8*NUM_REQ  packed write bytes
- gnt_o  out  NUM_REQ  one-hot grant, held for the whole transaction
- done_o  out  1  one-cycle completion pulse to granted requester
- rdata_o  out  8  read byte, valid with done_o
- status_o  out  2  valid with done_o: 0 OK, 1 NAK, 2 arbitration-lost/error, 3 timeout
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register select: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  controller interrupt (command done)

## Operation
- After reset: write CSR=0xC0 (core enable + interrupt enable), then IDLE. No grant issued before this write is acked.
- IDLE: if any req_i, grant the first asserting requester at or after the round-robin pointer; pointer then moves to grant index+1 (mod NUM_REQ). Pointer resets to 0.
- Sequence per grant (each "CMD x" = write CMDR=x, wait irq_i, read CMDR, decode bits 7 DON, 6 NAK, 5 AL, 4 ERR):
  - DPR=I2C_BUS_ID; CMD 0x06 (Set Bus)
  - CMD 0x04 (Start)
  - DPR={addr,rw}; CMD 0x01 (Write)
  - write: DPR=wdata; CMD 0x01. read: CMD 0x03 (Read with NAK); read DPR into rdata
  - CMD 0x05 (Stop); then RESP
- NAK after address or data byte: skip remaining data steps, issue Stop, status 1.
- AL or ERR: no Stop, go to RESP with status 2.
- irq_i not seen within TIMEOUT_CYCLES: recovery: write CSR=0x00, then CSR=0xC0, status 3.
- RESP: done_o for one cycle; gnt_o drops the following cycle; return to IDLE. rdata_o is 0x00 for writes and for any non-OK status.

## Timing
- Reset values: cyc_o, stb_o, we_o=0; adr_o=0; dat_o=0x00; gnt_o=0; done_o=0; rdata_o=0x00; status_o=0.
- Wishbone access: cyc_o/stb_o/we_o/adr_o/dat_o asserted together, held stable until ack_i sampled high; all deasserted on the next edge. At least one idle cycle separates consecutive accesses. Read data captured from dat_i in the ack_i cycle.
- Irq wait: the timeout counter is cleared when the CMDR write is acked and counts each cycle irq_i is low. The CMDR read is issued the cycle after irq_i is sampled high.
- Grant issued the cycle after req_i is sampled in IDLE. req_i changes on a non-granted line during a transaction are ignored. A requester dropping req_i mid-transaction does not abort it.
- Reset asserted mid-access: all outputs take reset values on that edge, including cyc_o/stb_o; a pending done_o is lost; the CSR enable write repeats after release.

## Test plan
- Write: req_i[0]=1, addr=0x22, wdata=0x5A, slave ACKs -> Wishbone writes in order: DPR 0x00, CMDR 0x06, CMDR 0x04, DPR 0x44, CMDR 0x01, DPR 0x5A, CMDR 0x01, CMDR 0x05; bus shows 0x44, 0x5A; done_o with status 0.
- Read: req_i[1]=1, rw=1, addr=0x22, slave returns 0xA7 -> DPR 0x45 written, CMDR 0x03 issued, done_o with rdata_o=0xA7, status 0.
- Address NAK: no slave at 0x10 -> Stop (CMDR 0x05) still issued, no data-byte writes, status 1.
- Arbitration: both req_i asserted from reset -> requester 0 served first, then 1; 0 re-requesting during 1's transaction is served after 1.
- Timeout: irq_i held low after Start, TIMEOUT_CYCLES=100 -> CSR 0x00 then CSR 0xC0 written, done_o with status 3 roughly 100 cycles after the Start ack.
- Reset mid-transaction: rst_n_i low for 1 cycle while stb_o=1 -> cyc_o=stb_o=0 next edge, no done_o, and CSR 0xC0 is the first access after release.
